bit_serializer: RTL and testbench
=================================

# bit_serializer

Parallel-to-serial front end for the serial sequence-detection path. Accepts WIDTH-bit words over a valid/ready handshake and emits them one bit per clock on a single-bit output that drives the detector's `din` input directly. Runs back-to-back words with no idle bubble. Forces the line to a defined idle level between words so the downstream detector never sees stale bits.

## Interface
- `WIDTH`, 8: bits per input word, ≥2.
- `MSB_FIRST`, 1: 1 = bit WIDTH-1 is shifted out first; 0 = bit 0 first.
- `clk`  in  1  single clock; all logic on posedge.
- `rst`  in  1  reset; asynchronous, active-high.
- `s_data`  in  WIDTH  word to serialize; sampled only on handshake.
- `s_valid`  in  1  upstream has a word on `s_data`.
- `s_ready`  out  1  block will accept a word this cycle.
- `dout`  out  1  serial bit; connects to the detector `din`.
- `dout_valid`  out  1  `dout` carries a payload (or parity) bit this cycle.
- `busy`  out  1  a word is in flight (state ≠ IDLE).

## Operation
- Handshake: a word is accepted at a posedge where `s_valid && s_ready`. `s_data` is ignored at all other times.
- States:
  - IDLE: nothing in flight.
  - SHIFT: payload bits being emitted.
  - PARITY: exists only with the macro; see Configuration.
- IDLE → SHIFT: on accept. Loads the shift register and clears `bit_cnt`.
- SHIFT, `bit_cnt < WIDTH-1`: advance one bit per cycle; `bit_cnt++`.
- SHIFT, last bit (`bit_cnt == WIDTH-1`):
  - accept → reload and stay in SHIFT;
  - else → IDLE.
- `s_ready` is combinational and equals `!rst && (state==IDLE || final cycle of current word)`. It never depends on `s_valid`.
- `bit_cnt` width: $clog2(WIDTH). It never exceeds WIDTH-1; there is no wrap past the word boundary.
- `dout` is a registered output: the current head of the shift register.
  - Shift direction is set by `MSB_FIRST`.
  - Vacated positions fill with 0.
- Idle level: `dout`=0 and `dout_valid`=0 in IDLE.
- `busy` = 1 in SHIFT and PARITY, 0 in IDLE.
- Upstream stalls (`s_valid`=0 at a word end) produce idle cycles with `dout`=0. This is intended; the detector treats them as 0 bits.
- Reset asserted mid-word: the partial word is discarded immediately (asynchronous). There is no resume. The first word after release starts from bit 0 of the new data.

## Timing
- Reset values:
  - state=IDLE, `bit_cnt`=0, shift register=0;
  - `dout`=0, `dout_valid`=0, `busy`=0, `s_ready`=0.
- `s_ready` rises combinationally once `rst` deasserts.
- Latency: word accepted at edge N → first bit on `dout` with `dout_valid`=1 during cycle N+1 (after edge N).
- Word occupies WIDTH consecutive cycles, or WIDTH+1 with parity.
- Back-to-back: accept on the final cycle gives the next word's first bit in the cycle immediately after. Sustained throughput is 1 bit/clk with zero bubbles.
- `dout` and `dout_valid` change only on clk edges or on async reset; they are glitch-free for the detector.

## Configuration
- Macro: `BIT_SERIALIZER_PARITY_EN`.
- Defined:
  - After the last payload bit, SHIFT → PARITY for one cycle.
  - `dout` = even parity (XOR of all WIDTH bits of the accepted word); `dout_valid`=1.
  - The PARITY cycle is the word's final cycle: `s_ready`=1 there and a new word can be accepted.
  - Parity is computed at accept time from `s_data`.
- Undefined:
  - No PARITY state and no parity logic.
  - The last payload bit is the final cycle.
  - Words are exactly WIDTH cycles.

## Test plan
- WIDTH=8, MSB_FIRST=1, single word 8'h6C → `dout` = 0,1,1,0,1,1,0,0 over 8 cycles starting the cycle after accept. `dout_valid` high for exactly 8 cycles. `s_ready` high in the 8th cycle. Then `dout`=0, `dout_valid`=0, `busy`=0.
- `s_valid` held high with 8'hA5 then 8'h3C → 16 consecutive valid bits 1010_0101_0011_1100. No gap. Exactly two accepts.
- MSB_FIRST=0, word 8'h01 → `dout` = 1,0,0,0,0,0,0,0. Changing `s_data` to 8'hFF while `s_ready`=0 → no effect on the in-flight word.
- Reset pulse after 3 bits of 8'hFF → `dout`/`dout_valid`/`busy` go to 0 immediately. After release, 8'h0F is sent whole: 0,0,0,0,1,1,1,1 with no remnant of 8'hFF.
- `s_valid`=0 for 5 cycles after reset → `s_ready`=1, `dout`=0, `dout_valid`=0 throughout.
- With `BIT_SERIALIZER_PARITY_EN`, word 8'h07 → 8 payload bits then a 9th valid bit = 1. Word 8'h03 → 9th bit = 0. Back-to-back accept on the parity cycle gives no bubble.

Source files
------------

// File: rtl/bit_serializer.sv
// bit_serializer: valid/ready word-to-bit serializer; optional even-parity trailer bit under BIT_SERIALIZER_PARITY_EN
`timescale 1ns/1ps
module bit_serializer #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] s_data,
    input  logic             s_valid,
    output logic             s_ready,
    output logic             dout,
    output logic             dout_valid,
    output logic             busy
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SHIFT = 2'd1;
`ifdef BIT_SERIALIZER_PARITY_EN
    localparam logic [1:0] PARITY = 2'd2;
    logic par;
`endif
    logic [1:0]       state;
    logic [CW-1:0]    bit_cnt;
    logic [WIDTH-1:0] sreg;
    logic             final_cyc;
    logic             accept;

    function automatic logic head(input logic [WIDTH-1:0] d);
        return MSB_FIRST ? d[WIDTH-1] : d[0];
    endfunction

    function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] d);
        return MSB_FIRST ? d << 1 : d >> 1;
    endfunction

    // The last cycle of a word is where the next word may be taken without a bubble
`ifdef BIT_SERIALIZER_PARITY_EN
    assign final_cyc = state == PARITY;
`else
    assign final_cyc = state == SHIFT && bit_cnt == LAST;
`endif
    assign s_ready = !rst && (state == IDLE || final_cyc);
    assign accept  = s_valid && s_ready;
    assign busy    = state != IDLE;

    // dout is loaded with the head bit at accept so the first bit appears the cycle after the handshake
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            bit_cnt    <= '0;
            sreg       <= '0;
            dout       <= 1'b0;
            dout_valid <= 1'b0;
`ifdef BIT_SERIALIZER_PARITY_EN
            par        <= 1'b0;
`endif
        end else if (accept) begin
            state      <= SHIFT;
            bit_cnt    <= '0;
            sreg       <= advance(s_data);
            dout       <= head(s_data);
            dout_valid <= 1'b1;
`ifdef BIT_SERIALIZER_PARITY_EN
            par        <= ^s_data;
`endif
        end else if (state == SHIFT && bit_cnt != LAST) begin
            bit_cnt <= bit_cnt + CW'(1);
            sreg    <= advance(sreg);
            dout    <= head(sreg);
`ifdef BIT_SERIALIZER_PARITY_EN
        end else if (state == SHIFT) begin
            state <= PARITY;
            dout  <= par;
`endif
        end else begin
            state      <= IDLE;
            bit_cnt    <= '0;
            dout       <= 1'b0;
            dout_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_bit_serializer.sv
// tb_bit_serializer: scoreboard bench for bit_serializer, MSB-first and LSB-first instances; honours BIT_SERIALIZER_PARITY_EN
`timescale 1ns/1ps
module tb_bit_serializer;
`ifdef BIT_SERIALIZER_PARITY_EN
    localparam int NB = 9;
`else
    localparam int NB = 8;
`endif
    logic       clk = 0;
    logic       rst;
    logic [7:0] d_m, d_l;
    logic       v_m, v_l;
    logic       rdy_m, o_m, ov_m, b_m;
    logic       rdy_l, o_l, ov_l, b_l;
    bit         qm[$];
    bit         ql[$];
    int         vec = 0;
    int         err = 0;

    bit_serializer #(.WIDTH(8), .MSB_FIRST(1)) u_m (
        .clk(clk), .rst(rst), .s_data(d_m), .s_valid(v_m),
        .s_ready(rdy_m), .dout(o_m), .dout_valid(ov_m), .busy(b_m)
    );

    bit_serializer #(.WIDTH(8), .MSB_FIRST(0)) u_l (
        .clk(clk), .rst(rst), .s_data(d_l), .s_valid(v_l),
        .s_ready(rdy_l), .dout(o_l), .dout_valid(ov_l), .busy(b_l)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic obs, input logic exp);
        vec++;
        assert (obs === exp) else begin
            err++;
            $error("FAIL %s observed=%b expected=%b at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic push(input bit lsb, input logic [7:0] d);
        for (int i = 0; i < 8; i++) begin
            if (lsb) ql.push_back(d[i]);
            else qm.push_back(d[7-i]);
        end
`ifdef BIT_SERIALIZER_PARITY_EN
        if (lsb) ql.push_back(^d);
        else qm.push_back(^d);
`endif
    endtask

    // Called at a negedge: checks this cycle's outputs against the scoreboard, then drives next inputs
    task automatic cyc(input logic vm, input logic [7:0] dm, input logic vl, input logic [7:0] dl);
        bit rm, rl, em, el, am, al;
        rm = qm.size() <= 1;
        rl = ql.size() <= 1;
        am = qm.size() > 0;
        al = ql.size() > 0;
        em = am ? qm.pop_front() : 1'b0;
        el = al ? ql.pop_front() : 1'b0;
        chk("m_ready", rdy_m, rm);
        chk("m_busy", b_m, am);
        chk("m_valid", ov_m, am);
        chk("m_dout", o_m, em);
        chk("l_ready", rdy_l, rl);
        chk("l_busy", b_l, al);
        chk("l_valid", ov_l, al);
        chk("l_dout", o_l, el);
        v_m = vm;
        d_m = dm;
        v_l = vl;
        d_l = dl;
        if (vm && rm) push(0, dm);
        if (vl && rl) push(1, dl);
        @(negedge clk);
    endtask

    initial begin
        rst = 1;
        v_m = 0;
        v_l = 0;
        d_m = 8'h00;
        d_l = 8'h00;
        #1;
        chk("rst_dout", o_m, 1'b0);
        chk("rst_valid", ov_m, 1'b0);
        chk("rst_busy", b_m, 1'b0);
        chk("rst_ready", rdy_m, 1'b0);
        chk("rst_ready_l", rdy_l, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst = 0;
        #1;
        chk("rel_ready", rdy_m, 1'b1);
        @(negedge clk);
        repeat (5) cyc(0, 8'h00, 0, 8'h00);
        // single word, MSB first
        cyc(1, 8'h6C, 0, 8'h00);
        repeat (NB) cyc(0, 8'h00, 0, 8'h00);
        repeat (2) cyc(0, 8'h00, 0, 8'h00);
        // back-to-back with valid held high
        cyc(1, 8'hA5, 0, 8'h00);
        repeat (NB - 1) cyc(1, 8'h3C, 0, 8'h00);
        cyc(1, 8'h3C, 0, 8'h00);
        repeat (NB) cyc(0, 8'h00, 0, 8'h00);
        cyc(0, 8'h00, 0, 8'h00);
        // LSB first; data changes while not ready must not matter
        cyc(0, 8'h00, 1, 8'h01);
        repeat (NB) cyc(0, 8'h00, 0, 8'hFF);
        cyc(0, 8'h00, 0, 8'h00);
        // parity words back-to-back on both instances
        cyc(1, 8'h07, 1, 8'h07);
        repeat (NB - 1) cyc(1, 8'h03, 1, 8'h03);
        cyc(1, 8'h03, 1, 8'h03);
        repeat (NB) cyc(0, 8'h00, 0, 8'h00);
        cyc(0, 8'h00, 0, 8'h00);
        // reset mid-word after three bits
        cyc(1, 8'hFF, 1, 8'hFF);
        repeat (3) cyc(0, 8'h00, 0, 8'h00);
        #2 rst = 1;
        #1;
        chk("mid_rst_dout", o_m, 1'b0);
        chk("mid_rst_valid", ov_m, 1'b0);
        chk("mid_rst_busy", b_m, 1'b0);
        chk("mid_rst_ready", rdy_m, 1'b0);
        chk("mid_rst_valid_l", ov_l, 1'b0);
        chk("mid_rst_busy_l", b_l, 1'b0);
        qm.delete();
        ql.delete();
        @(negedge clk);
        #2 rst = 0;
        #1;
        chk("rel2_ready", rdy_m, 1'b1);
        chk("rel2_ready_l", rdy_l, 1'b1);
        @(negedge clk);
        cyc(1, 8'h0F, 1, 8'h0F);
        repeat (NB) cyc(0, 8'h00, 0, 8'h00);
        repeat (2) cyc(0, 8'h00, 0, 8'h00);
        $display("== %0d vectors applied, %0d miscompares ==", vec, err);
        $finish;
    end
endmodule
